// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the SRAM-like req/addr_ok/data_ok protocol.
// Backed by a word-addressed RAM of 2**ADDR_W 32-bit words. It accepts up to DEPTH
// outstanding requests and answers them strictly in order, LATENCY cycles after acceptance.
// Optional feature macro: SRAM_RESP_STALL_EN adds LFSR-driven random backpressure on addr_ok.
module sram_like_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Backing store; contents survive reset.
  logic [31:0]       r_mem [2**ADDR_W];

  // Outstanding-request queue: control state is reset, payload is not.
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [DEPTH-1:0]  r_vld;
  logic [LAT_W-1:0]  r_cnt  [DEPTH];
  logic [DEPTH-1:0]  r_is_wr;
  logic [31:0]       r_data [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_stall_ok;
  logic              w_unused;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Byte address to word index; low bits and bits above the RAM alias away.
  assign w_idx    = addr[ADDR_W+1:2];
  assign w_unused = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Taps 16,14,13,11 give a maximal-length sequence.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Free-running LFSR; low two bits at zero refuse a request (about one cycle in four).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_stall_ok = (r_lfsr[1:0] != 2'b00);
`else
  assign w_stall_ok = 1'b1;
`endif

  // addr_ok depends only on registered state, so there is no path from pop to accept;
  // a full queue blocks a push even when the head pops on the same edge.
  assign addr_ok = (r_count < CNT_FULL) && w_stall_ok;
  assign w_push  = req && addr_ok;

  // Head is presented once its countdown expires; the initiator always takes it.
  assign data_ok = r_vld[r_head] && (r_cnt[r_head] == '0);
  assign w_pop   = data_ok;
  assign rdata   = (data_ok && !r_is_wr[r_head]) ? r_data[r_head] : 32'h0;

  // Write port: accepted writes update the enabled byte lanes on the accept edge.
  always_ff @(posedge clk) begin
    if (w_push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Entry payload: a read snapshots the word on its accept edge, a write carries zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_is_wr[r_tail] <= wr;
      r_data[r_tail]  <= wr ? 32'h0 : r_mem[w_idx];
    end
  end

  // Queue control: occupancy, pointers, per-entry valid and latency countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - LAT_W'(1);
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= ptr_next(r_head);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_cnt[r_tail] <= CNT_INIT;
        r_tail        <= ptr_next(r_tail);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: scoreboard bench for sram_like_responder.
// Two instances share the request bus: u_dut_a (DEPTH=2, LATENCY=1) and u_dut_b
// (DEPTH=2, LATENCY=3). Each accepted request pushes its expected rdata and due cycle;
// the response monitor pops and compares whenever data_ok is seen.
module tb_sram_like_responder;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a, req_b, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
  logic [31:0] rdata_a, rdata_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cycles = 0;
  int   stall_cycles = 0;
  bit   measure = 1'b0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];

  sram_like_responder #(.ADDR_W(12), .DEPTH(2), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
  );

  sram_like_responder #(.ADDR_W(12), .DEPTH(2), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model update for a request about to be accepted on the coming edge.
  task automatic commit(input bit sel_b);
    int          idx;
    logic [31:0] cur;
    exp_t        e;
    idx = int'(addr[13:2]);
    if (sel_b) cur = mem_b.exists(idx) ? mem_b[idx] : 32'h0;
    else       cur = mem_a.exists(idx) ? mem_a[idx] : 32'h0;
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      end
      if (sel_b) mem_b[idx] = cur;
      else       mem_a[idx] = cur;
      e.data = 32'h0;
    end else begin
      e.data = cur;
    end
    e.due = cyc + (sel_b ? LAT_B : LAT_A);
    if (sel_b) sb_b.push_back(e);
    else       sb_a.push_back(e);
  endtask

  // Holds req until accepted (bounded); returns the index of the accepting edge.
  task automatic drive_req(input bit sel_b, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, output int acc_cyc);
    bit done;
    done    = 1'b0;
    acc_cyc = -1;
    wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    req_a = !sel_b;
    req_b = sel_b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (measure && !sel_b) req_cycles++;
      if (sel_b ? addr_ok_b : addr_ok_a) begin
        commit(sel_b);
        acc_cyc = cyc + 1;
        done    = 1'b1;
      end else if (measure && !sel_b) begin
        stall_cycles++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk(sel_b ? "b_accept_timeout" : "a_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_resp(input bit sel_b);
    exp_t e;
    if (sel_b) begin
      if (sb_b.size() == 0) chk("b_spurious_data_ok", 32'(data_ok_b), 32'd0);
      else begin
        e = sb_b.pop_front();
        chk("b_rdata", rdata_b, e.data);
        chk("b_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      if (sb_a.size() == 0) chk("a_spurious_data_ok", 32'(data_ok_a), 32'd0);
      else begin
        e = sb_a.pop_front();
        chk("a_rdata", rdata_a, e.data);
        chk("a_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  // Response monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_ok_a) check_resp(1'b0);
      if (data_ok_b) check_resp(1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3;
    bit in_range;
    req_a = 1'b0; req_b = 1'b0; wr = 1'b0; size = 2'd2;
    addr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok_a", 32'(addr_ok_a), 32'd1);
    chk("rst_data_ok_a", 32'(data_ok_a), 32'd0);
    chk("rst_rdata_a",   rdata_a,        32'h0);
    chk("rst_addr_ok_b", 32'(addr_ok_b), 32'd1);
    chk("rst_data_ok_b", 32'(data_ok_b), 32'd0);
    chk("rst_rdata_b",   rdata_b,        32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full write then read back; partial write; write then read on the next cycle; alias.
    drive_req(1'b0, 1'b1, 32'h1c000000, 32'hDEADBEEF, 4'hF, t0);
    drive_req(1'b0, 1'b0, 32'h1c000000, 32'h0, 4'h0, t1);
    drive_req(1'b0, 1'b1, 32'h1c000000, 32'h00001234, 4'b0011, t0);
    drive_req(1'b0, 1'b0, 32'h1c000000, 32'h0, 4'h0, t1);
    drive_req(1'b0, 1'b1, 32'h1c000040, 32'h5A5A5A5A, 4'hF, t0);
    drive_req(1'b0, 1'b0, 32'h1c000040, 32'h0, 4'h0, t1);
`ifndef SRAM_RESP_STALL_EN
    chk("raw_read_next_cycle", 32'(t1 - t0), 32'd1);
`endif
    drive_req(1'b0, 1'b0, 32'h1c004003, 32'h0, 4'h0, t1);
    idle(4);

    // LATENCY=3 instance: three reads with req held, queue depth 2.
    drive_req(1'b1, 1'b1, 32'h00000100, 32'h11111111, 4'hF, t0);
    drive_req(1'b1, 1'b1, 32'h00000104, 32'h22222222, 4'hF, t0);
    drive_req(1'b1, 1'b1, 32'h00000108, 32'h33333333, 4'hF, t0);
    idle(6);
    drive_req(1'b1, 1'b0, 32'h00000100, 32'h0, 4'h0, t1);
    drive_req(1'b1, 1'b0, 32'h00000104, 32'h0, 4'h0, t2);
    drive_req(1'b1, 1'b0, 32'h00000108, 32'h0, 4'h0, t3);
    idle(8);
`ifdef SRAM_RESP_STALL_EN
    chk("full_blocks_third", 32'(t3 - t1 >= 4), 32'd1);
`else
    chk("second_accept_gap", 32'(t2 - t1), 32'd1);
    chk("third_waits_for_pop", 32'(t3 - t1), 32'd4);
`endif
    chk("a_idle_before_reset", 32'(sb_a.size()), 32'd0);
    chk("b_idle_before_reset", 32'(sb_b.size()), 32'd0);

    // Reset while two reads are outstanding: they must never be answered.
    drive_req(1'b1, 1'b0, 32'h00000100, 32'h0, 4'h0, t1);
    drive_req(1'b1, 1'b0, 32'h00000104, 32'h0, 4'h0, t2);
    req_b = 1'b0;
    reset = 1'b1;
    sb_a.delete();
    sb_b.delete();
    @(negedge clk);
    chk("mid_rst_data_ok_b", 32'(data_ok_b), 32'd0);
    chk("mid_rst_rdata_b",   rdata_b,        32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_addr_ok_b", 32'(addr_ok_b), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_stale_b", 32'(data_ok_b), 32'd0);
    end
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b0, 32'h00000108, 32'h0, 4'h0, t3);
    idle(6);

    // Random traffic on the LATENCY=1 instance over a pre-written window of words.
    for (int i = 0; i < 16; i++) begin
      drive_req(1'b0, 1'b1, ($urandom & 32'hFFFF_C000) | 32'((64 + i) << 2) | ($urandom & 32'h3),
                $urandom, 4'hF, t0);
    end
    measure = 1'b1;
    for (int i = 0; i < 1000 && errors < 20; i++) begin
      drive_req(1'b0, 1'($urandom_range(0, 1)),
                ($urandom & 32'hFFFF_C000) | 32'((64 + $urandom_range(0, 15)) << 2) | ($urandom & 32'h3),
                $urandom, 4'($urandom_range(0, 15)), t0);
    end
    measure = 1'b0;
    idle(10);
    chk("a_all_answered", 32'(sb_a.size()), 32'd0);
    chk("b_all_answered", 32'(sb_b.size()), 32'd0);
`ifdef SRAM_RESP_STALL_EN
    in_range = (stall_cycles * 100 >= req_cycles * 20) && (stall_cycles * 100 <= req_cycles * 30);
    chk("stall_ratio_20_30pct", 32'(in_range), 32'd1);
`else
    chk("no_backpressure", 32'(stall_cycles), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
